// File: rtl/multi_region_integrity.sv
// ============================================================================
// multi_region_integrity : write-protection monitor for N_REG address regions
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_region_integrity #(
  parameter int                      N_REG         = 2,
  parameter logic [16*N_REG-1:0]     REG_BASE      = {16'h0170, 16'h0160},
  parameter logic [16*N_REG-1:0]     REG_END       = {16'h017F, 16'h0168},
  parameter logic [N_REG-1:0]        REG_TRUSTED   = '0,
  parameter logic [15:0]             TCB_BASE      = 16'hA000,
  parameter logic [15:0]             TCB_END       = 16'hA0FF,
  parameter logic [15:0]             RESET_HANDLER = 16'h0000,
  parameter int                      MIN_HOLD      = 4,
  parameter int                      CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      pc,
  input  logic [15:0]      data_addr,
  input  logic             data_wr,
  input  logic [15:0]      dma_addr,
  input  logic             dma_en,
  input  logic             dma_we,
  output logic             reset,
  output logic [N_REG-1:0] viol_map,
  output logic [1:0]       viol_src,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int                c_hold_w      = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [c_hold_w-1:0] c_hold_reload = c_hold_w'(MIN_HOLD - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [c_hold_w-1:0] hold_cnt_q, hold_cnt_d;
  logic                reset_q, reset_d;
  logic [N_REG-1:0]    viol_map_q, viol_map_d;
  logic [1:0]          viol_src_q, viol_src_d;
  logic [CNT_W-1:0]    viol_cnt_q, viol_cnt_d;

  logic                in_tcb;
  logic [N_REG-1:0]    cpu_hit;
  logic [N_REG-1:0]    dma_hit;
  logic [N_REG-1:0]    hit_map;
  logic [1:0]          src_now;
  logic                viol;

  assign in_tcb = (pc >= TCB_BASE) && (pc <= TCB_END);

  // Trust only exempts CPU writes; DMA writes always count.
  for (genvar i = 0; i < N_REG; i++) begin : g_region
    logic [15:0] base;
    logic [15:0] lim;
    assign base       = REG_BASE[16*i +: 16];
    assign lim        = REG_END[16*i +: 16];
    assign cpu_hit[i] = data_wr && (data_addr >= base) && (data_addr <= lim)
                        && !(REG_TRUSTED[i] && in_tcb);
    assign dma_hit[i] = dma_en && dma_we && (dma_addr >= base) && (dma_addr <= lim);
  end

  assign hit_map = cpu_hit | dma_hit;
  assign src_now = {|dma_hit, |cpu_hit};
  assign viol    = |hit_map;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (viol) begin
          state_d    = ST_HOLD;
          hold_cnt_d = c_hold_reload;
        end
      end
      ST_HOLD: begin
        if (viol) begin
          hold_cnt_d = c_hold_reload;
        end else if (hold_cnt_q == '0) begin
          state_d = ST_WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (viol) begin
          state_d    = ST_HOLD;
          hold_cnt_d = c_hold_reload;
        end else if (pc == RESET_HANDLER) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = c_hold_reload;
      end
    endcase
  end

  // Capture replaces the log on a fresh incident; otherwise it accumulates
  // until software is back in RUN, where it is frozen for inspection.
  always_comb begin
    reset_d    = (state_d != ST_RUN);
    viol_map_d = viol_map_q;
    viol_src_d = viol_src_q;
    viol_cnt_d = viol_cnt_q;
    if (state_q == ST_RUN) begin
      if (viol) begin
        viol_map_d = hit_map;
        viol_src_d = src_now;
      end
    end else begin
      viol_map_d = viol_map_q | hit_map;
      viol_src_d = viol_src_q | src_now;
    end
    if (viol && (viol_cnt_q != {CNT_W{1'b1}})) begin
      viol_cnt_d = viol_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= c_hold_reload;
      reset_q    <= 1'b1;
      viol_map_q <= '0;
      viol_src_q <= '0;
      viol_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      reset_q    <= reset_d;
      viol_map_q <= viol_map_d;
      viol_src_q <= viol_src_d;
      viol_cnt_q <= viol_cnt_d;
    end
  end

  assign reset    = reset_q;
  assign viol_map = viol_map_q;
  assign viol_src = viol_src_q;
  assign viol_cnt = viol_cnt_q;

endmodule

`default_nettype wire
